// File: rtl/btn_conditioner_if.sv
// Button bundle between the pushbutton pins and the debounced game-side outputs.
// The slave modport is the conditioner itself; master is whoever drives the raw pins.
interface btn_conditioner_if;
  logic [4:0] btn_raw;
  logic [4:0] btn_level;
  logic [4:0] btn_pulse;
  logic       any_pulse;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_pulse,
    input  any_pulse
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_pulse,
    output any_pulse
  );
endinterface

// File: rtl/btn_conditioner.sv
// Five-button synchronizer, debouncer and press-strobe generator.
// Optional macro BTN_LOCKOUT_EN: pulse only when no other button is held, lowest index wins ties.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic              clk,
  input  logic              resetn,
  btn_conditioner_if.slave  btn
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [4:0]       sync1;
  logic [4:0]       sync2;
  logic [CNT_W-1:0] cnt [5];
  logic [4:0]       level;
  logic [4:0]       pulse;
  logic             any_q;
  logic [4:0]       rise;
  logic [4:0]       grant;

  // A debounced 0->1 transition happens on this edge for each bit in rise.
  always_comb begin
    rise = 5'b0;
    for (int i = 0; i < 5; i++) begin
      rise[i] = sync2[i] && !level[i] && (cnt[i] == CNT_MAX);
    end
  end

`ifdef BTN_LOCKOUT_EN
  // Others must be released (pre-edge level); among simultaneous rises the lowest index wins.
  always_comb begin
    grant = 5'b0;
    for (int i = 0; i < 5; i++) begin
      grant[i] = rise[i] && ((level & ~(5'b1 << i)) == 5'b0)
                 && ((rise & ((5'b1 << i) - 5'b1)) == 5'b0);
    end
  end
`else
  always_comb begin
    grant = rise;
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1 <= 5'b0;
      sync2 <= 5'b0;
      level <= 5'b0;
      pulse <= 5'b0;
      any_q <= 1'b0;
      for (int i = 0; i < 5; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= btn.btn_raw;
      sync2 <= sync1;
      pulse <= grant;
      any_q <= |grant;
      for (int i = 0; i < 5; i++) begin
        if (sync2[i] == level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          level[i] <= sync2[i];
          cnt[i]   <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign btn.btn_level = level;
  assign btn.btn_pulse = pulse;
  assign btn.any_pulse = any_q;

endmodule
